// File: rtl/knight_rider_scanner.sv
`default_nettype none
// ============================================================================
// Module      : knight_rider_scanner
// Description : Edge-detects a slow timing bit and bounces a single lit LED
//               back and forth across an LED bank (Knight Rider scanner).
//               Position counter, direction FSM and registered LED driver.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   LED_WIDTH   number of LEDs driven (2..32)
// Ports:
//   aclk        in   system clock
//   aresetn     in   reset, asynchronous assert, active-low
//   tick_in     in   slow timing bit, synchronous to aclk; each rise = 1 step
//   enable      in   level; low forces idle, high runs the scan
//   led         out  LED drive, registered
//   dir         out  0 = moving towards MSB, 1 = moving towards LSB
//   pos         out  current lit index, zero-extended to 5 bits
//   step        out  one-cycle pulse with each new led value
//   sweep_done  out  one-cycle pulse on the bounce at index 0
// Configuration:
//   KNIGHT_RIDER_TRAIL_EN  when defined, the previous position stays lit as a
//                          trail next to the current one.
// ============================================================================
module knight_rider_scanner #(
  parameter int LED_WIDTH = 8
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 tick_in,
  input  logic                 enable,
  output logic [LED_WIDTH-1:0] led,
  output logic                 dir,
  output logic [4:0]           pos,
  output logic                 step,
  output logic                 sweep_done
);

  localparam logic [4:0] POS_MAX = 5'(LED_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SCAN_UP   = 2'd1,
    SCAN_DOWN = 2'd2
  } state_t;

  state_t state;
  state_t next_state;
  logic   tick_q;
  logic   tick_edge;
  logic [4:0]           next_pos;
  logic                 next_step;
  logic                 next_sweep;
  logic [LED_WIDTH-1:0] next_led;
`ifdef KNIGHT_RIDER_TRAIL_EN
  logic [4:0]           prev_pos;
  logic [4:0]           next_prev;
`endif

  assign tick_edge = tick_in & ~tick_q;

  function automatic logic [LED_WIDTH-1:0] one_hot(input logic [4:0] idx);
    one_hot = {{(LED_WIDTH-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Next-state / next-position decode. The enable level is checked before
  // the tick edge, so enable transitions always win over a coincident edge.
  always_comb begin
    next_state = state;
    next_pos   = pos;
    next_step  = 1'b0;
    next_sweep = 1'b0;
`ifdef KNIGHT_RIDER_TRAIL_EN
    next_prev  = prev_pos;
`endif
    if (!enable) begin
      next_state = IDLE;
      next_pos   = 5'd0;
`ifdef KNIGHT_RIDER_TRAIL_EN
      next_prev  = 5'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // Entering the scan discards any edge seen this cycle.
          next_state = SCAN_UP;
          next_pos   = 5'd0;
`ifdef KNIGHT_RIDER_TRAIL_EN
          next_prev  = 5'd0;
`endif
        end
        SCAN_UP: begin
          if (tick_edge) begin
            next_step = 1'b1;
`ifdef KNIGHT_RIDER_TRAIL_EN
            next_prev = pos;
`endif
            if (pos == POS_MAX) begin
              // Bounce without dwelling on the top LED.
              next_state = SCAN_DOWN;
              next_pos   = POS_MAX - 5'd1;
            end else begin
              next_pos   = pos + 5'd1;
            end
          end
        end
        SCAN_DOWN: begin
          if (tick_edge) begin
            next_step = 1'b1;
`ifdef KNIGHT_RIDER_TRAIL_EN
            next_prev = pos;
`endif
            if (pos == 5'd0) begin
              // Bounce at the bottom closes one full round trip.
              next_state = SCAN_UP;
              next_pos   = 5'd1;
              next_sweep = 1'b1;
            end else begin
              next_pos   = pos - 5'd1;
            end
          end
        end
        default: begin
          next_state = IDLE;
          next_pos   = 5'd0;
        end
      endcase
    end

    if (next_state == IDLE) begin
      next_led = '0;
    end else begin
`ifdef KNIGHT_RIDER_TRAIL_EN
      next_led = one_hot(next_pos) | one_hot(next_prev);
`else
      next_led = one_hot(next_pos);
`endif
    end
  end

  // All outputs are registered alongside the state so they change together.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      tick_q     <= 1'b0;
      pos        <= 5'd0;
      dir        <= 1'b0;
      led        <= '0;
      step       <= 1'b0;
      sweep_done <= 1'b0;
`ifdef KNIGHT_RIDER_TRAIL_EN
      prev_pos   <= 5'd0;
`endif
    end else begin
      tick_q     <= tick_in;
      state      <= next_state;
      pos        <= next_pos;
      dir        <= (next_state == SCAN_DOWN);
      led        <= next_led;
      step       <= next_step;
      sweep_done <= next_sweep;
`ifdef KNIGHT_RIDER_TRAIL_EN
      prev_pos   <= next_prev;
`endif
    end
  end

endmodule
`default_nettype wire
